// File: rtl/debounced_encoder.sv
// rtl/debounced_encoder.sv - debounced active-low one-hot to 2-bit encoder
// Synchronizes D/E, qualifies a pattern for STABLE_CYCLES, then emits one code per press.
module debounced_encoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [0:3] D,
    input  logic       E,
    input  logic       ACK,
    output logic       A,
    output logic       B,
    output logic       V,
    output logic       ERR
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;
    localparam logic [7:0] LIMIT     = 8'(STABLE_CYCLES);

    logic [0:3] d_s1_q, d_s2_q;
    logic       e_s1_q, e_s2_q;
    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [0:3] cap_q, cap_d;
    logic       a_q, a_d, b_q, b_d, v_q, v_d, err_q, err_d;

    logic [0:3] p;
    logic       p_idle;
    logic       p_single;
    logic [2:0] n_low;
    logic [1:0] cap_code;

    // Synchronizers reset to the idle level so reset release never looks like a press.
    always_ff @(posedge CLK) begin
        if (RST) begin
            d_s1_q <= 4'b1111;
            d_s2_q <= 4'b1111;
            e_s1_q <= 1'b1;
            e_s2_q <= 1'b1;
        end else begin
            d_s1_q <= D;
            d_s2_q <= d_s1_q;
            e_s1_q <= E;
            e_s2_q <= e_s1_q;
        end
    end

    assign p        = e_s2_q ? 4'b1111 : d_s2_q;
    assign p_idle   = (p == 4'b1111);
    assign n_low    = 3'($countones(~p));
    assign p_single = (n_low == 3'd1);

    always_comb begin
        cap_code = 2'd0;
        case (cap_q)
            4'b0111: cap_code = 2'd0;
            4'b1011: cap_code = 2'd1;
            4'b1101: cap_code = 2'd2;
            4'b1110: cap_code = 2'd3;
            default: cap_code = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        a_d     = a_q;
        b_d     = b_q;
        v_d     = v_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!p_idle) begin
                    state_d = S_SETTLE;
                    cap_d   = p;
                    cnt_d   = 8'd1;
                end
            end
            S_SETTLE: begin
                if (p == cap_q) begin
                    if (cnt_q >= LIMIT) begin
                        cnt_d = 8'd0;
                        if (p_single) begin
                            {a_d, b_d} = cap_code;
                            v_d        = 1'b1;
                            state_d    = S_HOLD;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (p_idle) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cap_d = p;
                    cnt_d = 8'd1;
                end
            end
            S_HOLD: begin
                if (ACK) begin
                    v_d     = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Counts consecutive idle cycles; exits before the counter can exceed LIMIT.
                if (!p_idle) begin
                    cnt_d = 8'd0;
                end else if (cnt_q + 8'd1 >= LIMIT) begin
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            cap_q   <= 4'b1111;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            v_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            a_q     <= a_d;
            b_q     <= b_d;
            v_q     <= v_d;
            err_q   <= err_d;
        end
    end

    assign A   = a_q;
    assign B   = b_q;
    assign V   = v_q;
    assign ERR = err_q;

endmodule

// File: tb/tb_debounced_encoder.sv
// tb/tb_debounced_encoder.sv - directed self-checking bench for debounced_encoder
module tb_debounced_encoder;

    logic       CLK;
    logic       RST;
    logic [0:3] D;
    logic       E;
    logic       ACK;
    logic       A, B, V, ERR;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [0:3] d;
        logic       e;
        logic       v;
        logic [1:0] ab;
        logic       err;
    } vec_t;

    vec_t vecs [8];

    debounced_encoder #(.STABLE_CYCLES(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .D(D),
        .E(E),
        .ACK(ACK),
        .A(A),
        .B(B),
        .V(V),
        .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        D   = 4'b1111;
        E   = 1'b0;
        ACK = 1'b0;
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
    endtask

    initial begin
        vecs[0] = '{d: 4'b0111, e: 1'b0, v: 1'b1, ab: 2'd0, err: 1'b0};
        vecs[1] = '{d: 4'b1011, e: 1'b0, v: 1'b1, ab: 2'd1, err: 1'b0};
        vecs[2] = '{d: 4'b1101, e: 1'b0, v: 1'b1, ab: 2'd2, err: 1'b0};
        vecs[3] = '{d: 4'b1110, e: 1'b0, v: 1'b1, ab: 2'd3, err: 1'b0};
        vecs[4] = '{d: 4'b0110, e: 1'b0, v: 1'b0, ab: 2'd0, err: 1'b1};
        vecs[5] = '{d: 4'b0000, e: 1'b0, v: 1'b0, ab: 2'd0, err: 1'b1};
        vecs[6] = '{d: 4'b0000, e: 1'b1, v: 1'b0, ab: 2'd0, err: 1'b0};
        vecs[7] = '{d: 4'b1111, e: 1'b0, v: 1'b0, ab: 2'd0, err: 1'b0};

        RST = 1'b1;
        D   = 4'b1111;
        E   = 1'b0;
        ACK = 1'b0;
        tick(2);
        RST = 1'b0;
        check("reset_v", 32'(V), 32'd0);
        check("reset_a", 32'(A), 32'd0);
        check("reset_b", 32'(B), 32'd0);
        check("reset_err", 32'(ERR), 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            D = vecs[i].d;
            E = vecs[i].e;
            tick(6);
            check($sformatf("vec%0d_early_v", i), 32'(V), 32'd0);
            check($sformatf("vec%0d_early_err", i), 32'(ERR), 32'd0);
            tick(1);
            check($sformatf("vec%0d_v", i), 32'(V), 32'(vecs[i].v));
            check($sformatf("vec%0d_ab", i), 32'({A, B}), 32'(vecs[i].ab));
            check($sformatf("vec%0d_err", i), 32'(ERR), 32'(vecs[i].err));
            tick(1);
            check($sformatf("vec%0d_err_pulse_end", i), 32'(ERR), 32'd0);
            check($sformatf("vec%0d_v_held", i), 32'(V), 32'(vecs[i].v));
        end

        // Hold stability, single ACK clear, release gating, new press on D[3]
        do_reset();
        D = 4'b1101;
        tick(7);
        check("hold_v", 32'(V), 32'd1);
        check("hold_ab", 32'({A, B}), 32'd2);
        for (int k = 0; k < 20; k++) begin
            if (k == 5) D = 4'b0111;
            if (k == 10) E = 1'b1;
            tick(1);
            check($sformatf("hold_stable_v%0d", k), 32'(V), 32'd1);
            check($sformatf("hold_stable_ab%0d", k), 32'({A, B}), 32'd2);
        end
        E   = 1'b0;
        D   = 4'b1110;
        ACK = 1'b1;
        tick(1);
        check("ack_clear_v", 32'(V), 32'd0);
        check("ack_keep_ab", 32'({A, B}), 32'd2);
        tick(3);
        check("ack_held_v", 32'(V), 32'd0);
        ACK = 1'b0;
        tick(15);
        check("still_pressed_no_v", 32'(V), 32'd0);
        D = 4'b1111;
        tick(3);
        D = 4'b1110;
        tick(15);
        check("short_release_no_v", 32'(V), 32'd0);
        D = 4'b1111;
        tick(8);
        D = 4'b1110;
        tick(6);
        check("repress_early_v", 32'(V), 32'd0);
        tick(1);
        check("repress_v", 32'(V), 32'd1);
        check("repress_ab", 32'({A, B}), 32'd3);

        // Bounce on D[1]
        do_reset();
        D = 4'b1011;
        tick(1);
        check("bounce_v0", 32'(V), 32'd0);
        tick(1);
        check("bounce_v1", 32'(V), 32'd0);
        D = 4'b1111;
        tick(1);
        check("bounce_v2", 32'(V), 32'd0);
        D = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check($sformatf("bounce_settle_v%0d", k), 32'(V), 32'd0);
        end
        tick(1);
        check("bounce_final_v", 32'(V), 32'd1);
        check("bounce_final_ab", 32'({A, B}), 32'd1);

        // Multi-line press, release, then a clean single press
        do_reset();
        D = 4'b0110;
        tick(7);
        check("multi_err", 32'(ERR), 32'd1);
        check("multi_v", 32'(V), 32'd0);
        tick(1);
        check("multi_err_end", 32'(ERR), 32'd0);
        tick(10);
        check("multi_held_err", 32'(ERR), 32'd0);
        check("multi_held_v", 32'(V), 32'd0);
        D = 4'b1111;
        tick(7);
        D = 4'b0111;
        tick(6);
        check("after_multi_early_v", 32'(V), 32'd0);
        tick(1);
        check("after_multi_v", 32'(V), 32'd1);
        check("after_multi_ab", 32'({A, B}), 32'd0);

        // Disabled enable masks all lines
        do_reset();
        E = 1'b1;
        D = 4'b0000;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            check($sformatf("disabled_v%0d", k), 32'(V), 32'd0);
            check($sformatf("disabled_err%0d", k), 32'(ERR), 32'd0);
        end
        E = 1'b0;
        tick(7);
        check("enabled_multi_err", 32'(ERR), 32'd1);

        // Reset during HOLD
        do_reset();
        D = 4'b1101;
        tick(7);
        check("pre_rst_v", 32'(V), 32'd1);
        RST = 1'b1;
        D   = 4'b1111;
        tick(1);
        RST = 1'b0;
        check("rst_hold_v", 32'(V), 32'd0);
        check("rst_hold_a", 32'(A), 32'd0);
        check("rst_hold_b", 32'(B), 32'd0);
        tick(10);
        check("rst_idle_v", 32'(V), 32'd0);
        D = 4'b1101;
        tick(6);
        check("rst_repress_early_v", 32'(V), 32'd0);
        tick(1);
        check("rst_repress_v", 32'(V), 32'd1);
        check("rst_repress_ab", 32'({A, B}), 32'd2);

        // Reset during SETTLE restarts qualification from scratch
        do_reset();
        D = 4'b1011;
        tick(4);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        tick(6);
        check("rst_settle_early_v", 32'(V), 32'd0);
        tick(1);
        check("rst_settle_v", 32'(V), 32'd1);
        check("rst_settle_ab", 32'({A, B}), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
